// File: rtl/mc_ctrl.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/write-back over a shared datapath.
// Latency: R/addi/sw 4 cycles, lw 5, beq/j 3, illegal 2, plus one cycle per MemReady=0 in a memory state.
// Backpressure: FETCH/MEMRD/MEMWR hold state and keep the request steady while MemReady=0.
module mc_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] Op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] State,
  output logic       Illegal
);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] RWB    = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8;
  localparam logic [3:0] JUMP   = 4'd9;
  localparam logic [3:0] ADDIEX = 4'd10;
  localparam logic [3:0] ADDIWB = 4'd11;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  logic [3:0] state;
  logic [3:0] state_nxt;

  // Zero only qualifies PCWriteCond in the datapath; the FSM never branches on it.
  logic zero_unused;
  assign zero_unused = Zero;

  // Next-state selection from the current step, opcode and memory handshake.
  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH:  state_nxt = MemReady ? DECODE : FETCH;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_R:         state_nxt = EXEC;
          OP_BEQ:       state_nxt = BRANCH;
          OP_J:         state_nxt = JUMP;
          OP_ADDI:      state_nxt = ADDIEX;
          default:      state_nxt = FETCH;
        endcase
      end
      MEMADR: begin
        if (Op == OP_LW)      state_nxt = MEMRD;
        else if (Op == OP_SW) state_nxt = MEMWR;
        else                  state_nxt = FETCH;
      end
      MEMRD:  state_nxt = MemReady ? MEMWB : MEMRD;
      MEMWB:  state_nxt = FETCH;
      MEMWR:  state_nxt = MemReady ? FETCH : MEMWR;
      EXEC:   state_nxt = RWB;
      RWB:    state_nxt = FETCH;
      BRANCH: state_nxt = FETCH;
      JUMP:   state_nxt = FETCH;
      ADDIEX: state_nxt = ADDIWB;
      ADDIWB: state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  // State register; reset aborts any instruction in flight and restarts at FETCH.
  always_ff @(posedge CLK) begin
    if (RST) state <= FETCH;
    else     state <= state_nxt;
  end

  // Moore control decode, with fetch strobes qualified by MemReady and everything forced low in reset.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'd0;
    ALUOp       = 2'd0;
    PCSource    = 2'd0;
    Illegal     = 1'b0;
    State       = state;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'd1;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      DECODE: begin
        ALUSrcB = 2'd3;
        Illegal = !(Op == OP_R || Op == OP_J || Op == OP_BEQ ||
                    Op == OP_ADDI || Op == OP_LW || Op == OP_SW);
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'd2;
      end
      RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'd1;
        PCWriteCond = 1'b1;
        PCSource    = 2'd1;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'd2;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
      end
      default: ;
    endcase
    if (RST) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'd0;
      ALUOp       = 2'd0;
      PCSource    = 2'd0;
      Illegal     = 1'b0;
      State       = 4'd0;
    end
  end

endmodule
